// File: rtl/div8_pkg.sv
// div8_pkg: shared definitions for the sequential 8-bit divider controller.
//   - div8_state_e : controller states (idle, iterate, sign fix-up, done)
//   - IterCount    : restoring-division steps per operation
//   - DivZeroQuot  : quotient reported for a zero divisor
//   - neg8()       : two's complement negation of an 8-bit value
package div8_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix,
    StDone
  } div8_state_e;

  localparam int unsigned IterCount = 8;
  localparam logic [7:0] DivZeroQuot = 8'hFF;

  function automatic logic [7:0] neg8(input logic [7:0] x);
    return ~x + 8'd1;
  endfunction

endpackage

// File: rtl/SUB8bit.sv
// SUB8bit: 8-bit subtractor, Result = A - B.
//   A, B   : operands
//   Result : difference modulo 256
//   Borrow : carry-out of A + ~B + 1; 1 means A >= B (no borrow occurred)
module SUB8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Result,
  output logic       Borrow
);

  logic [8:0] sum;

  assign sum    = {1'b0, A} + {1'b0, ~B} + 9'd1;
  assign Result = sum[7:0];
  assign Borrow = sum[8];

endmodule

// File: rtl/div8_seq_ctrl.sv
// div8_seq_ctrl: multi-cycle 8-bit restoring divider sharing one SUB8bit instance.
//   clk, rst_n             : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    : operand handshake; operands sampled only on acceptance
//   dividend, divisor      : A and B operands
//   out_valid / out_ready  : result handshake; results held stable while out_valid
//   quotient, remainder    : A / B and A mod B
//   div_zero               : result came from a zero divisor (quotient 0xFF, remainder A)
//   busy                   : high whenever the controller is not idle
// Build option: define DIV8_SIGNED_EN for two's complement operands. Division then runs on
// magnitudes and an extra fix-up cycle restores the signs (remainder follows the dividend).
module div8_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_zero,
  output logic       busy
);

  import div8_pkg::*;

  localparam logic [2:0] LastCnt = 3'(IterCount - 1);

  div8_state_e state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  b_q;         // divisor (magnitude in the signed build)
  logic [7:0]  q_q;         // dividend shifting out MSB-first, quotient shifting in
  // Partial remainder. The ninth bit of R is never stored: after every step the kept value
  // is below the divisor, so it fits in 8 bits; the ninth bit only exists transiently in T.
  logic [7:0]  r_q;
  logic [7:0]  quotient_q;
  logic [7:0]  remainder_q;
  logic        div_zero_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        busy_q;

`ifdef DIV8_SIGNED_EN
  logic        q_neg_q;     // signs of operands differ
  logic        r_neg_q;     // dividend negative
`endif

  // Operand magnitudes as captured at acceptance
  logic [7:0] dvd_mag;
  logic [7:0] dvs_mag;

`ifdef DIV8_SIGNED_EN
  assign dvd_mag = dividend[7] ? neg8(dividend) : dividend;
  assign dvs_mag = divisor[7] ? neg8(divisor) : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // One restoring step
  logic [8:0] t;
  logic [7:0] sub_res;
  logic       sub_carry;
  logic       success;
  logic [7:0] r_next;
  logic [7:0] q_next;

  SUB8bit u_sub (
    .A      (t[7:0]),
    .B      (b_q),
    .Result (sub_res),
    .Borrow (sub_carry)
  );

  always_comb begin
    t       = {r_q, q_q[7]};
    success = t[8] | sub_carry;
    r_next  = success ? sub_res : t[7:0];
    q_next  = {q_q[6:0], success};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      b_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef DIV8_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            b_q        <= dvs_mag;
            q_q        <= dvd_mag;
            r_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef DIV8_SIGNED_EN
            q_neg_q    <= dividend[7] ^ divisor[7];
            r_neg_q    <= dividend[7];
`endif
            if (divisor == 8'h00) begin
              state_q     <= StDone;
              quotient_q  <= DivZeroQuot;
              remainder_q <= dividend;
              div_zero_q  <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StIter;
            end
          end
        end

        StIter: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LastCnt) begin
`ifdef DIV8_SIGNED_EN
            state_q <= StFix;
`else
            state_q     <= StDone;
            quotient_q  <= q_next;
            remainder_q <= r_next;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b1;
`endif
          end
        end

        StFix: begin
`ifdef DIV8_SIGNED_EN
          // -128 / -1: magnitude 128 with equal signs stays 0x80, the wrapped result
          quotient_q  <= q_neg_q ? neg8(q_q) : q_q;
          remainder_q <= r_neg_q ? neg8(r_q) : r_q;
          div_zero_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
`else
          // Unreachable in the unsigned build
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
`endif
        end

        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div8_seq_ctrl.sv
// tb_div8_seq_ctrl: directed, table-driven bench for div8_seq_ctrl.
// Latency is counted as the number of cycles from the accepting edge (inclusive) to the
// first cycle with out_valid high.
module tb_div8_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;
  logic       busy;

  int checks;
  int errors;

  div8_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_dz;
    int         exp_lat;
  } vec_t;

`ifdef DIV8_SIGNED_EN
  localparam int NLat = 10;
  localparam logic [7:0] BpQ = 8'hF8;  // -56 / 7 = -8 r 0
  localparam logic [7:0] BpR = 8'h00;
`else
  localparam int NLat = 9;
  localparam logic [7:0] BpQ = 8'd28;  // 200 / 7 = 28 r 4
  localparam logic [7:0] BpR = 8'd4;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation, wait for out_valid; leaves the result pending in DONE.
  task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b, output int lat);
    int k;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("in_ready before accept", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!out_valid) chk("out_valid timeout", 0, 1);
    lat = k + 1;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid after handshake", int'(out_valid), 0);
    chk("in_ready after handshake", int'(in_ready), 1);
    chk("busy after handshake", int'(busy), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'h00;
    divisor   = 8'h00;

`ifdef DIV8_SIGNED_EN
    vecs.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 10});
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10});
    vecs.push_back('{8'h64, 8'h0A, 8'h0A, 8'h00, 1'b0, 10});
    vecs.push_back('{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1});
`else
    vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 9});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9});
    vecs.push_back('{8'd3,   8'd200, 8'd0,   8'd3,  1'b0, 9});
    vecs.push_back('{8'd200, 8'd129, 8'd1,   8'd71, 1'b0, 9});
    vecs.push_back('{8'd5,   8'd0,   8'hFF,  8'd5,  1'b1, 1});
    vecs.push_back('{8'd100, 8'd10,  8'd10,  8'd0,  1'b0, 9});
`endif

    #12;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset div_zero", int'(div_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start_and_wait(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d quotient", i), int'(quotient), int'(vecs[i].exp_q));
      chk($sformatf("v%0d remainder", i), int'(remainder), int'(vecs[i].exp_r));
      chk($sformatf("v%0d div_zero", i), int'(div_zero), int'(vecs[i].exp_dz));
      handshake();
    end

    // Backpressure: result held while new operands are offered
    start_and_wait(8'd200, 8'd7, lat);
    chk("bp latency", lat, NLat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 8'd9;
      divisor  = 8'd3;
      @(posedge clk);
      #1;
      chk("bp out_valid", int'(out_valid), 1);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp quotient", int'(quotient), int'(BpQ));
      chk("bp remainder", int'(remainder), int'(BpR));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp handshake in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp not captured busy", int'(busy), 0);
    chk("bp not captured quotient", int'(quotient), int'(BpQ));

    // Reset in the middle of iteration
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid busy", int'(busy), 1);
    chk("mid in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst quotient", int'(quotient), 0);
    chk("rst remainder", int'(remainder), 0);
    chk("rst div_zero", int'(div_zero), 0);
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) chk("no out_valid in reset", 1, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    start_and_wait(8'd100, 8'd10, lat);
    chk("post-reset latency", lat, NLat);
    chk("post-reset quotient", int'(quotient), 10);
    chk("post-reset remainder", int'(remainder), 0);
    chk("post-reset div_zero", int'(div_zero), 0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div8_seq_ctrl.md
# div8_seq_ctrl

Sequential 8-bit divider controller that time-shares a single `SUB8bit` subtractor instance across eight restoring-division iterations. Operands arrive on a valid/ready input port, and results leave on a valid/ready output port. The block sits beside the ALU datapath as its multi-cycle DIV/MOD unit, so no second subtractor is added for division.

## Interface
Parameters:
- none; width is fixed at 8 bits, matching the subtractor.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `dividend`  in  8  A operand.
- `divisor`  in  8  B operand.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `quotient`  out  8  A / B.
- `remainder`  out  8  A mod B.
- `div_zero`  out  1  divisor was 0 for this result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - ITER: 8 cycles, counter 0..7.
  - FIX: `DIV8_SIGNED_EN` only.
  - DONE: `out_valid`=1.
- IDLE, on `in_valid` and `in_ready`:
  - Latch the operands.
  - Clear the 9-bit partial remainder R and the quotient shift register Q.
  - If divisor==0, go to DONE; otherwise go to ITER.
- ITER step, one per cycle:
  - Form T = {R[7:0], Q[7]} (9 bits); shift Q left.
  - Drive the subtractor with A=T[7:0] and B=divisor.
  - Success = T[8] OR subtractor carry-out (carry-out 1 = no borrow).
  - On success: R ← Result, Q[0] ← 1. Otherwise: R ← T, Q[0] ← 0.
  - Q initially holds the dividend and is shifted out MSB-first.
- After count 7, go to DONE (or FIX when signed).
- DONE:
  - Hold `quotient`, `remainder` and `div_zero` stable until `out_valid` and `out_ready` are both high.
  - Then go to IDLE.
- Divide by zero: `quotient`=0xFF, `remainder`=dividend, `div_zero`=1.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only at acceptance.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `busy`=0
  - `quotient`=0x00
  - `remainder`=0x00
  - `div_zero`=0
- Accept at edge N. ITER occupies cycles N+1..N+8. `out_valid` rises after edge N+8, so latency is 9 cycles.
- Divide by zero: `out_valid` rises after edge N+1.
- Signed build: FIX adds 1 cycle, giving 10 cycles (divide by zero stays at 1 cycle).
- Handoff: output handshake at edge M leaves IDLE in cycle M+1, with `in_ready`=1. No same-cycle output-to-input pass-through, so throughput is at most 1 result per 10 cycles unsigned.
- Backpressure: `out_ready`=0 holds DONE indefinitely, with outputs stable.
- Reset mid-operation: immediate return to IDLE with reset values. The partial result is discarded and no `out_valid` pulse occurs.

## Configuration
- `DIV8_SIGNED_EN` defined:
  - Operands are two's complement.
  - Magnitudes are taken at acceptance.
  - FIX negates Q when the signs differ and negates R when the dividend is negative.
  - The remainder carries the dividend's sign.
  - -128 / -1 gives `quotient`=0x80, `remainder`=0x00.
- `DIV8_SIGNED_EN` undefined: unsigned only; FIX does not exist.

## Structure
- Shared package `div8_pkg`:
  - state enum (IDLE, ITER, FIX, DONE)
  - iteration count constant 8
  - divide-by-zero quotient constant 0xFF
- Sub-module: one instance of the existing `SUB8bit`; its `Borrow` output is used as carry-out.
- Signed negation in FIX may reuse the same instance (A=0, B=value) or use local logic. Either way, no second full subtractor.

## Test plan
- Unsigned 200 / 7, `out_ready`=1 → `quotient`=28 (0x1C), `remainder`=4, `div_zero`=0, `out_valid` 9 cycles after acceptance.
- 255 / 1 and 3 / 200 → 255 r 0; 0 r 3. 200 / 129 exercises the T[8]=1 path → 1 r 71.
- 5 / 0 → `quotient`=0xFF, `remainder`=0x05, `div_zero`=1, latency 1 cycle.
- Hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid` with new operands → outputs stable, `in_ready`=0, new operands not captured.
- Assert `rst_n`=0 during iteration 4 → all outputs return to reset values immediately; the next operation 100 / 10 → 10 r 0.
- (`DIV8_SIGNED_EN`) 0x9C / 0x07, i.e. -100 / 7 → `quotient`=0xF2 (-14), `remainder`=0xFE (-2), latency 10 cycles. 0x80 / 0xFF → 0x80 r 0x00.
